// File: rtl/adc_pkg.sv
// Shared types and constants for the AD9248 dual-channel averaging path.
package adc_pkg;

    localparam int ADC_W = 14;

    function automatic int acc_w(input int n, input int log2_win_max);
        return n + log2_win_max;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ADD_A = 2'd2,
        S_ADD_B = 2'd3
    } state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/adc_avg_out_buf.sv
// Two-entry result hold: presents channel A then channel B on one valid/ready stream.
module adc_avg_out_buf
    import adc_pkg::*;
#(
    parameter int N = ADC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] res_a,
    input  logic [N-1:0] res_b,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ch,
    output logic         out_valid
);

    logic [N-1:0] res_a_q, res_a_d;
    logic [N-1:0] res_b_q, res_b_d;
    logic         pend_a_q, pend_a_d;
    logic         pend_b_q, pend_b_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_a_q  <= '0;
            res_b_q  <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            res_a_q  <= res_a_d;
            res_b_q  <= res_b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    always_comb begin
        res_a_d  = res_a_q;
        res_b_d  = res_b_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        if (out_valid && out_ready) begin
            if (pend_a_q) pend_a_d = 1'b0;
            else          pend_b_d = 1'b0;
        end
        // The scheduler only loads when both entries are empty.
        if (load) begin
            res_a_d  = res_a;
            res_b_d  = res_b;
            pend_a_d = 1'b1;
            pend_b_d = 1'b1;
        end
    end

    always_comb begin
        out_valid = pend_a_q | pend_b_q;
        out_ch    = (!pend_a_q && pend_b_q) ? CH_B : CH_A;
        if (pend_a_q)      out_data = res_a_q;
        else if (pend_b_q) out_data = res_b_q;
        else               out_data = '0;
    end

endmodule

// File: rtl/adc_avg_sched.sv
// Block averager for two ADC channels sharing one adder; results leave A then B.
//   state   | meaning
//   S_IDLE  | stopped, waiting for enable rising edge
//   S_WAIT  | armed, waiting for sample_stb
//   S_ADD_A | accumulate held channel A sample
//   S_ADD_B | accumulate held channel B sample, count, complete window
module adc_avg_sched
    import adc_pkg::*;
#(
    parameter int N            = ADC_W,
    parameter int LOG2_WIN_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [2:0]   win_log2,
    input  logic         sample_stb,
    input  logic [N-1:0] adc_a,
    input  logic [N-1:0] adc_b,
    output logic [N-1:0] out_data,
    output logic         out_ch,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int         ACC_W = acc_w(N, LOG2_WIN_MAX);
    localparam int         CNT_W = LOG2_WIN_MAX + 1;
    localparam logic [2:0] W_MAX = 3'(LOG2_WIN_MAX);

    state_t             state_q, state_d;
    logic               enable_q, enable_d;
    logic [2:0]         w_q, w_d;
    logic [ACC_W-1:0]   acc_a_q, acc_a_d;
    logic [ACC_W-1:0]   acc_b_q, acc_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       hold_a_q, hold_a_d;
    logic [N-1:0]       hold_b_q, hold_b_d;
    logic               overrun_q, overrun_d;

    logic               start;
    logic [ACC_W-1:0]   add_lhs;
    logic [N-1:0]       add_rhs;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   win_len;
    logic               win_done;
    logic               load;
    logic [N-1:0]       res_a;
    logic [N-1:0]       res_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            enable_q  <= 1'b0;
            w_q       <= '0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            cnt_q     <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            w_q       <= w_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            cnt_q     <= cnt_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            overrun_q <= overrun_d;
        end
    end

    // Single adder, steered by state between the two channels.
    always_comb begin
        start    = enable && !enable_q;
        add_lhs  = (state_q == S_ADD_A) ? acc_a_q  : acc_b_q;
        add_rhs  = (state_q == S_ADD_A) ? hold_a_q : hold_b_q;
        sum      = add_lhs + ACC_W'(add_rhs);
        cnt_inc  = cnt_q + CNT_W'(1);
        win_len  = CNT_W'(1) << w_q;
        win_done = (state_q == S_ADD_B) && (cnt_inc == win_len);
        // acc_a already holds the final A sample by the time ADD_B runs.
        res_a    = N'(acc_a_q >> w_q);
        res_b    = N'(sum >> w_q);
        load     = win_done && !out_valid;
    end

    always_comb begin
        state_d   = state_q;
        enable_d  = enable;
        w_d       = w_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        cnt_d     = cnt_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        overrun_d = overrun_q;
        if (start) overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    w_d     = (win_log2 > W_MAX) ? W_MAX : win_log2;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (sample_stb) begin
                    hold_a_d = adc_a;
                    hold_b_d = adc_b;
                    state_d  = S_ADD_A;
                end
            end
            S_ADD_A: begin
                acc_a_d = sum;
                if (sample_stb) overrun_d = 1'b1;
                state_d = S_ADD_B;
            end
            S_ADD_B: begin
                if (sample_stb) overrun_d = 1'b1;
                if (win_done) begin
                    acc_a_d = '0;
                    acc_b_d = '0;
                    cnt_d   = '0;
                    if (out_valid) overrun_d = 1'b1;
                end else begin
                    acc_b_d = sum;
                    cnt_d   = cnt_inc;
                end
                state_d = enable ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    adc_avg_out_buf #(.N(N)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .res_a     (res_a),
        .res_b     (res_b),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    assign busy    = (state_q != S_IDLE);
    assign overrun = overrun_q;

endmodule

// File: doc/adc_avg_sched.md
Name: adc_avg_sched

Overview:
- Sequencer/scheduler for the AD9248 dual-channel capture path.
- Time-shares one adder between channel A and channel B to form per-channel block averages over 2^W samples.
- Presents results A then B on a single valid/ready output stream to downstream logic (UART/packetizer).
- Flags overruns when the ADC strobe or the consumer cannot be serviced.

Parameters:
- N, 14, ADC sample width per channel (unsigned).
- LOG2_WIN_MAX, 4, maximum log2 of averaging window; accumulator width is N+LOG2_WIN_MAX.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; rising edge starts a new averaging session.
- win_log2  in  3  window exponent W; sampled only on the enable rising edge.
- sample_stb  in  1  one-cycle pulse: adc_a/adc_b valid this cycle.
- adc_a  in  N  channel A sample.
- adc_b  in  N  channel B sample.
- out_data  out  N  averaged result.
- out_ch  out  1  0 = channel A, 1 = channel B.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset: FSM=IDLE; accumulators, sample counter, hold regs and result regs = 0; out_valid=0, out_ch=0, out_data=0, busy=0, overrun=0.
- FSM states: IDLE, WAIT, ADD_A, ADD_B.
  - IDLE -> WAIT on enable rising edge. Latch W=min(win_log2, LOG2_WIN_MAX). Clear accumulators, counter and overrun.
  - WAIT -> ADD_A on sample_stb. Capture adc_a and adc_b into hold regs the same cycle.
  - ADD_A: acc_a += hold_a through the shared adder; go to ADD_B.
  - ADD_B: acc_b += hold_b; counter++. If counter reaches 2^W, do window completion. Go to WAIT, or to IDLE if enable=0.
  - WAIT with enable=0 -> IDLE. A partial window is discarded; accumulators are cleared on the next start.
- Window completion, in the cycle after ADD_B:
  - If no results are pending: res_a=acc_a>>W, res_b=acc_b>>W (truncate, no rounding), pend_a=pend_b=1.
  - If any result is still pending: new results are dropped and overrun is set.
  - In both cases, accumulators and counter restart at 0.
- sample_stb in ADD_A or ADD_B, or a coincident stb on the ADD_B->WAIT cycle: the sample is dropped and overrun is set. Minimum legal strobe spacing is 3 cycles.
- sample_stb in IDLE: ignored, no flag.
- Output stream:
  - out_valid=pend_a|pend_b. Present A while pend_a, otherwise B.
  - The handshake clears the presented pend bit.
  - Data and out_ch are held stable while valid && !ready.
  - Pending outputs drain independently of enable and of FSM state.
- Latency: the final strobe of a window at cycle t gives ADD_A at t+1, ADD_B at t+2, and out_valid (A) at t+3. With out_ready=1, B is presented at t+4.
- W=0: every strobe produces the raw samples as outputs.
- Max accumulator value is (2^N-1)*2^LOG2_WIN_MAX; it never wraps.
- overrun is sticky. It clears only on reset or on the enable rising edge.
- Reset mid-window or mid-output: everything returns to reset values immediately and pending results are lost.

Decomposition:
- Shared package adc_pkg:
  - ADC_W=14 and ACC_W function.
  - FSM state enum (IDLE/WAIT/ADD_A/ADD_B).
  - Channel id constants CH_A=0, CH_B=1.
- One natural sub-module, adc_avg_out_buf: 2-entry result hold with valid/ready drain logic.
- The shared adder/accumulator stays inline.

Test Plan:
- W=2, stb every 4 cycles, A=100,104,108,112, B=8 ×4 -> out A=106 then B=8, out_ch 0 then 1, out_valid 3 cycles after the 4th stb.
- W=0, A=16383, B=0, out_ready=1 -> each stb yields A=16383 then B=0; W=7 requested -> clamped to 4, so 16 samples per result.
- out_ready=0 across two full windows (W=1) -> first results held stable, second dropped, overrun=1. Raise ready -> only the first pair drains.
- stb pulses 2 cycles apart -> second sample dropped, overrun=1, average uses only accepted samples; restart via enable -> overrun=0.
- enable low after 2 of 4 samples (W=2) -> busy=0 next WAIT, no output. Re-enable with 4 samples of A=50 -> A=50, no stale contribution.
- reset asserted while out_valid=1 and FSM in ADD_B -> next cycle all outputs 0, FSM IDLE, subsequent stb ignored.
